// File: rtl/pattern_pkg.sv
// Types and defaults shared between the serializer and the detector-side benches.
package pattern_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/pattern_serializer.sv
// Parallel-to-serial feeder for the pattern detector: valid/ready word input,
// one bit per clock out, with a one-word holding register for gapless streaming.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              abort,
  output logic              serial_pattern,
  output logic              enable,
  output logic              word_start
);

  localparam int              CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                ser_d, en_d, ws_d;
  logic                accept, load;
  logic [DATA_W-1:0]   load_word, shifted;

  // The bit about to go on the line always sits at the shifter's output end.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  assign data_ready = !hold_vld_q;
  assign accept     = data_valid && data_ready;
  assign shifted    = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    bit_cnt_d  = bit_cnt_q;
    ser_d      = 1'b0;
    en_d       = 1'b0;
    ws_d       = 1'b0;
    load       = 1'b0;
    load_word  = data_in;

    if (abort) begin
      state_d    = IDLE;
      hold_vld_d = 1'b0;
      bit_cnt_d  = '0;
    end else if (state_q == IDLE) begin
      if (accept) load = 1'b1;
    end else if (bit_cnt_q == LAST) begin
      // Word boundary: a pending hold word wins; hold is empty otherwise, so a
      // live handshake can go straight into the shifter.
      bit_cnt_d = '0;
      if (hold_vld_q) begin
        load       = 1'b1;
        load_word  = hold_q;
        hold_vld_d = 1'b0;
      end else if (accept) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (accept) begin
        hold_d     = data_in;
        hold_vld_d = 1'b1;
      end
      shift_d   = shifted;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      ser_d     = first_bit(shifted);
      en_d      = 1'b1;
    end

    if (load) begin
      state_d   = SHIFT;
      shift_d   = load_word;
      bit_cnt_d = '0;
      ser_d     = first_bit(load_word);
      en_d      = 1'b1;
      ws_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      hold_q         <= '0;
      hold_vld_q     <= 1'b0;
      bit_cnt_q      <= '0;
      serial_pattern <= 1'b0;
      enable         <= 1'b0;
      word_start     <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      bit_cnt_q      <= bit_cnt_d;
      serial_pattern <= ser_d;
      enable         <= en_d;
      word_start     <= ws_d;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: MSB-first instance plus an LSB-first instance.
module tb_pattern_serializer;
  import pattern_pkg::*;

  logic       clk;
  logic       rstb;
  logic [7:0] data_in;
  logic       data_valid, data_ready, abort, serial_pattern, enable, word_start;
  logic [7:0] l_data_in;
  logic       l_data_valid, l_data_ready, l_serial, l_enable, l_word_start;

  int checks   = 0;
  int failures = 0;

  pattern_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rstb(rstb), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .abort(abort), .serial_pattern(serial_pattern),
    .enable(enable), .word_start(word_start)
  );

  pattern_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rstb(rstb), .data_in(l_data_in), .data_valid(l_data_valid),
    .data_ready(l_data_ready), .abort(1'b0), .serial_pattern(l_serial),
    .enable(l_enable), .word_start(l_word_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
    checks++; if (serial_pattern !== 1'b0) begin failures++; $display("FAIL reset_serial got=%b exp=0", serial_pattern); end
    checks++; if (word_start !== 1'b0) begin failures++; $display("FAIL reset_word_start got=%b exp=0", word_start); end
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", data_ready); end
    checks++; if (l_enable !== 1'b0) begin failures++; $display("FAIL reset_lsb_enable got=%b exp=0", l_enable); end
    checks++; if (l_data_ready !== 1'b1) begin failures++; $display("FAIL reset_lsb_ready got=%b exp=1", l_data_ready); end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hB4;
    data_in = w; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (serial_pattern !== w[8-c]) begin failures++; $display("FAIL single_serial c=%0d got=%b exp=%b", c, serial_pattern, w[8-c]); end
      checks++; if (enable !== 1'b1) begin failures++; $display("FAIL single_enable c=%0d got=%b exp=1", c, enable); end
      checks++; if (word_start !== (c == 1)) begin failures++; $display("FAIL single_word_start c=%0d got=%b exp=%b", c, word_start, c == 1); end
      tick();
    end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL single_enable_end got=%b exp=0", enable); end
    checks++; if (serial_pattern !== 1'b0) begin failures++; $display("FAIL single_serial_end got=%b exp=0", serial_pattern); end
  endtask

  task automatic test_back_to_back();
    data_in = 8'hFF; data_valid = 1'b1;
    tick();
    data_in = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) data_valid = 1'b0;
      checks++; if (enable !== 1'b1) begin failures++; $display("FAIL b2b_enable c=%0d got=%b exp=1", c, enable); end
      checks++; if (serial_pattern !== (c <= 8)) begin failures++; $display("FAIL b2b_serial c=%0d got=%b exp=%b", c, serial_pattern, c <= 8); end
      checks++; if (word_start !== (c == 1 || c == 9)) begin failures++; $display("FAIL b2b_word_start c=%0d got=%b exp=%b", c, word_start, c == 1 || c == 9); end
      checks++; if (data_ready !== !(c >= 2 && c <= 8)) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, data_ready, !(c >= 2 && c <= 8)); end
      tick();
    end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL b2b_enable_end got=%b exp=0", enable); end
  endtask

  task automatic test_bypass();
    logic [15:0] stream;
    stream = 16'h3C81;
    data_in = 8'h3C; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 8) begin data_in = 8'h81; data_valid = 1'b1; end
      if (c == 9) data_valid = 1'b0;
      checks++; if (enable !== 1'b1) begin failures++; $display("FAIL bypass_enable c=%0d got=%b exp=1", c, enable); end
      checks++; if (serial_pattern !== stream[16-c]) begin failures++; $display("FAIL bypass_serial c=%0d got=%b exp=%b", c, serial_pattern, stream[16-c]); end
      checks++; if (word_start !== (c == 1 || c == 9)) begin failures++; $display("FAIL bypass_word_start c=%0d got=%b exp=%b", c, word_start, c == 1 || c == 9); end
      checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL bypass_ready c=%0d got=%b exp=1", c, data_ready); end
      tick();
    end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL bypass_enable_end got=%b exp=0", enable); end
  endtask

  task automatic test_abort();
    logic [7:0] w;
    w = 8'hAA;
    data_in = w; data_valid = 1'b1;
    tick();
    data_in = 8'h55;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) data_valid = 1'b0;
      if (c == 4) abort = 1'b1;
      checks++; if (serial_pattern !== w[8-c]) begin failures++; $display("FAIL abort_serial c=%0d got=%b exp=%b", c, serial_pattern, w[8-c]); end
      if (c >= 2) begin
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL abort_hold_ready c=%0d got=%b exp=0", c, data_ready); end
      end
      tick();
    end
    abort = 1'b0;
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL abort_enable got=%b exp=0", enable); end
    checks++; if (word_start !== 1'b0) begin failures++; $display("FAIL abort_word_start got=%b exp=0", word_start); end
    checks++; if (serial_pattern !== 1'b0) begin failures++; $display("FAIL abort_serial_after got=%b exp=0", serial_pattern); end
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", data_ready); end
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (enable !== 1'b0 || serial_pattern !== 1'b0) begin failures++; $display("FAIL abort_leak c=%0d enable=%b serial=%b exp=0/0", c, enable, serial_pattern); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    data_in = 8'hB4; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    checks++; if (enable !== 1'b1 || word_start !== 1'b1) begin failures++; $display("FAIL rst_mid_pre enable=%b ws=%b exp=1/1", enable, word_start); end
    #2 rstb = 1'b0;
    #1;
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_mid_enable got=%b exp=0", enable); end
    checks++; if (serial_pattern !== 1'b0) begin failures++; $display("FAIL rst_mid_serial got=%b exp=0", serial_pattern); end
    checks++; if (word_start !== 1'b0) begin failures++; $display("FAIL rst_mid_word_start got=%b exp=0", word_start); end
    #1 rstb = 1'b1;
    tick();
    tick();
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_mid_no_resume got=%b exp=0", enable); end
    w = 8'h0F;
    data_in = w; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (serial_pattern !== w[8-c] || enable !== 1'b1) begin failures++; $display("FAIL rst_mid_word c=%0d serial=%b enable=%b exp=%b/1", c, serial_pattern, enable, w[8-c]); end
      tick();
    end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_mid_enable_end got=%b exp=0", enable); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'h01;
    l_data_in = w; l_data_valid = 1'b1;
    tick();
    l_data_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (l_serial !== w[c-1]) begin failures++; $display("FAIL lsb_serial c=%0d got=%b exp=%b", c, l_serial, w[c-1]); end
      checks++; if (l_enable !== 1'b1 || l_word_start !== (c == 1)) begin failures++; $display("FAIL lsb_ctrl c=%0d enable=%b ws=%b exp=1/%b", c, l_enable, l_word_start, c == 1); end
      tick();
    end
    checks++; if (l_enable !== 1'b0) begin failures++; $display("FAIL lsb_enable_end got=%b exp=0", l_enable); end
  endtask

  initial begin
    rstb = 1'b0;
    data_in = '0; data_valid = 1'b0; abort = 1'b0;
    l_data_in = '0; l_data_valid = 1'b0;
    #3;
    test_reset();
    #9 rstb = 1'b1;
    tick();
    test_single();
    tick();
    test_back_to_back();
    tick();
    test_bypass();
    tick();
    test_abort();
    tick();
    test_reset_mid();
    tick();
    test_lsb_first();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Upstream feeder for the serial pattern detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on serial_pattern.
- Drives the detector's enable input high only while valid bits are on the line. When enable drops, the detector returns to its idle state between bursts.
- A one-word holding register allows back-to-back words to stream with no gap cycle.

Parameters:
- DATA_W, 8, width of each parallel word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit DATA_W-1 shifted out first; 0 = bit 0 first.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rstb  input  1  asynchronous active-low reset.
- data_in  input  DATA_W  parallel word to serialize.
- data_valid  input  1  data_in valid.
- data_ready  output  1  block can accept a word this cycle; combinational, equals !hold_vld.
- abort  input  1  synchronous flush of all buffered and in-flight data.
- serial_pattern  output  1  registered serial bit, meaningful only when enable = 1.
- enable  output  1  registered; high for every cycle carrying a valid bit.
- word_start  output  1  registered; high on the cycle the first bit of each word is on serial_pattern.

Behaviour:
- Reset (rstb = 0, async):
  - state = IDLE; shift_q, hold_q, hold_vld, bit_cnt all 0.
  - serial_pattern = 0, enable = 0, word_start = 0, data_ready = 1.
- Handshake: a word is accepted at a rising edge where data_valid && data_ready. data_in must stay stable while valid && !ready.
- State machine, state_t = {IDLE, SHIFT}:
  - IDLE, on handshake:
    - Load data_in straight into shift_q (bypass); go to SHIFT; bit_cnt = 0.
    - Next cycle: enable = 1, word_start = 1, serial_pattern = first bit.
    - Latency is 1 cycle from acceptance edge to first bit on the line.
  - IDLE, no handshake: enable = 0, serial_pattern = 0.
  - SHIFT, each cycle:
    - Present the next bit; bit_cnt increments.
    - A handshake in SHIFT writes hold_q and sets hold_vld.
  - SHIFT, last bit (bit_cnt == DATA_W-1):
    - If hold_vld: load hold_q into the shifter and clear hold_vld.
    - Else, if a handshake occurs this cycle: load data_in directly (bypass).
    - Either way, stay in SHIFT; the next cycle is bit 0 of the new word with word_start = 1 and enable staying high (no gap).
    - Otherwise return to IDLE; enable = 0 on the next cycle.
- Each word occupies exactly DATA_W consecutive enable-high cycles. Continuous input gives an unbroken enable.
- Bit order:
  - MSB_FIRST = 1: bit DATA_W-1 first, bit 0 last.
  - MSB_FIRST = 0: bit 0 first.
- Simultaneous events:
  - hold_vld = 1 forces data_ready = 0, so a hold write and a hold load never conflict.
  - A handshake on the last-bit cycle with hold empty uses the bypass path, not the hold.
- abort = 1 (synchronous, highest priority after reset):
  - Next edge: state = IDLE; clear hold_vld and bit_cnt; enable = 0, word_start = 0, serial_pattern = 0.
  - Any handshake in the same cycle is discarded; data_ready still reflects !hold_vld.
- Async reset mid-word: all outputs return to reset values immediately. The partial word is lost; no resumption.
- bit_cnt width is $clog2(DATA_W). It never exceeds DATA_W-1 and wraps to 0 on each word load.

Decomposition:
- Shared package pattern_pkg holds:
  - state_t enum {IDLE, SHIFT};
  - the default DATA_W constant, shared with the detector-side benches.
- No sub-module: the shifter, hold register and FSM form one module of about 150–200 lines.

Test Plan (DATA_W = 8, MSB_FIRST = 1 unless noted):
- Single word 8'hB4, accepted at edge 0:
  - serial_pattern = 1,0,1,1,0,1,0,0 on cycles 1–8;
  - enable high cycles 1–8 and low on cycle 9;
  - word_start high on cycle 1 only.
- Back-to-back 8'hFF then 8'h00, data_valid held high:
  - enable high for 16 consecutive cycles; word_start on cycles 1 and 9;
  - data_ready low from the second acceptance until the hold is loaded at cycle 8→9.
- Bypass on last bit: second word 8'h81 presented only during bit 8 of the first word:
  - no gap; cycle 9 = 1, cycle 16 = 1;
  - hold_vld never set.
- abort asserted during bit 4 of 8'hAA with 8'h55 held:
  - enable = 0 next cycle; data_ready = 1;
  - 8'h55 never appears on serial_pattern.
- rstb pulsed low mid-word:
  - enable, serial_pattern and word_start go to 0 asynchronously;
  - after release, a new word 8'h0F serializes correctly from bit 7.
- MSB_FIRST = 0, word 8'h01: serial_pattern = 1,0,0,0,0,0,0,0 on cycles 1–8.
